// File: rtl/uart_rx_os16.sv
// UART receiver, 8 data + parity + stop, 16x oversampling with 3-sample majority vote.
// Holds one received byte with error flags behind a valid/ready handshake.
module uart_rx_os16 #(
  parameter int CLK_DIV    = 27,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_in,
  input  logic       rx_ready,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       parity_bit_error,
  output logic       stop_bit_error,
  output logic       overrun_error,
  output logic       rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, rxs;
  logic [11:0] div_q;
  logic [3:0]  smp_q;
  logic [2:0]  idx_q;
  logic [7:0]  shf_q;
  logic        par_q;
  logic        v7_q, v8_q, v9_q;
  logic [7:0]  data_q;
  logic        valid_q, perr_q, serr_q, ovr_q, busy_q;

  logic tick, wrap, start_go, done, vote_wrap, vote_stop, load;

  assign rxs       = s2_q;
  assign tick      = (div_q == 12'(CLK_DIV - 1));
  assign wrap      = tick && (smp_q == 4'd15);
  assign start_go  = (state_q == IDLE) && !rxs;
  // Stop bit resolves at mid-bit so the next start edge is never missed.
  assign done      = (state_q == STOP) && tick && (smp_q == 4'd9);
  assign vote_wrap = (v7_q & v8_q) | (v7_q & v9_q) | (v8_q & v9_q);
  assign vote_stop = (v7_q & v8_q) | (v7_q & rxs)  | (v8_q & rxs);
  assign load      = !valid_q || rx_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rxs) state_d = START;
      START:   if (wrap) state_d = vote_wrap ? IDLE : DATA;
      DATA:    if (wrap && idx_q == 3'd7) state_d = PARITY;
      PARITY:  if (wrap) state_d = STOP;
      STOP:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= IDLE;
      div_q   <= '0;
      smp_q   <= '0;
      idx_q   <= '0;
      shf_q   <= '0;
      par_q   <= 1'b0;
      v7_q    <= 1'b0;
      v8_q    <= 1'b0;
      v9_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= rx_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);

      // Restarting the divider on the start edge aligns tick phase to the frame.
      if (start_go || tick) div_q <= '0;
      else                  div_q <= div_q + 12'd1;

      if (start_go)  smp_q <= '0;
      else if (tick) smp_q <= smp_q + 4'd1;

      if (tick && smp_q == 4'd7) v7_q <= rxs;
      if (tick && smp_q == 4'd8) v8_q <= rxs;
      if (tick && smp_q == 4'd9) v9_q <= rxs;

      if (state_q == START && wrap) idx_q <= '0;
      if (state_q == DATA && wrap) begin
        shf_q[idx_q] <= vote_wrap;
        idx_q        <= idx_q + 3'd1;
      end
      if (state_q == PARITY && wrap) par_q <= vote_wrap;

      if (done && load) begin
        data_q  <= shf_q;
        perr_q  <= ((^shf_q) ^ par_q) != 1'(PARITY_ODD);
        serr_q  <= ~vote_stop;
        valid_q <= 1'b1;
      end else begin
        if (done) ovr_q <= 1'b1;
        if (valid_q && rx_ready) valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_out      = data_q;
  assign rx_valid         = valid_q;
  assign parity_bit_error = perr_q;
  assign stop_bit_error   = serr_q;
  assign overrun_error    = ovr_q;
  assign rx_busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at CLK_DIV=4 (64 clk per bit).
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_in;
  logic       rx_ready;
  logic [7:0] rx_data_out;
  logic       rx_valid, parity_bit_error, stop_bit_error, overrun_error, rx_busy;

  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;
  logic [7:0] got_data = '0;
  logic       got_perr = 1'b0, got_serr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os16 #(.CLK_DIV(4), .PARITY_ODD(0)) dut (
    .clk(clk), .rstn(rstn), .rx_in(rx_in), .rx_ready(rx_ready),
    .rx_data_out(rx_data_out), .rx_valid(rx_valid),
    .parity_bit_error(parity_bit_error), .stop_bit_error(stop_bit_error),
    .overrun_error(overrun_error), .rx_busy(rx_busy)
  );

  // Latch whatever is presented while valid, and count valid cycles.
  always @(negedge clk) begin
    if (rx_valid) begin
      got_data = rx_data_out;
      got_perr = parity_bit_error;
      got_serr = stop_bit_error;
      vld_cnt  = vld_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic se);
    chk({tag, "_vcnt"}, vld_cnt, 1);
    chk({tag, "_data"}, got_data, d);
    chk({tag, "_perr"}, got_perr, pe);
    chk({tag, "_serr"}, got_serr, se);
  endtask

  initial begin
    rstn = 1'b0; rx_in = 1'b1; rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data_out, 8'h00);
    chk("rst_perr", parity_bit_error, 0);
    chk("rst_serr", stop_bit_error, 0);
    chk("rst_ovr", overrun_error, 0);
    chk("rst_busy", rx_busy, 0);
    rstn = 1'b1;
    repeat (20) @(negedge clk);

    // Clean frame, single-cycle valid with ready high
    vld_cnt = 0;
    send_frame(8'hA5, 1'b0, 1'b1);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    chk("a5_vlow", rx_valid, 0);

    // Wrong parity
    vld_cnt = 0;
    send_frame(8'h01, 1'b0, 1'b1);
    expect_frame("p01", 8'h01, 1'b1, 1'b0);

    // Stop error, then clean frame
    vld_cnt = 0;
    send_frame(8'h3C, 1'b0, 1'b0);
    expect_frame("s3c", 8'h3C, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    vld_cnt = 0;
    send_frame(8'h5A, 1'b0, 1'b1);
    expect_frame("n5a", 8'h5A, 1'b0, 1'b0);

    // False start
    vld_cnt = 0;
    rx_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("fs_busy_hi", rx_busy, 1);
    repeat (10) @(negedge clk);
    rx_in = 1'b1;
    repeat (60) @(negedge clk);
    chk("fs_busy_lo", rx_busy, 0);
    chk("fs_vcnt", vld_cnt, 0);
    chk("fs_ovr", overrun_error, 0);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    chk("ov1_valid", rx_valid, 1);
    chk("ov1_ovr", overrun_error, 0);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("ov2_valid", rx_valid, 1);
    chk("ov2_data", rx_data_out, 8'h11);
    chk("ov2_ovr", overrun_error, 1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ov_clr_valid", rx_valid, 0);
    chk("ov_sticky", overrun_error, 1);

    // Reset during data bit 4 of 0x77
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 ^ (i == 3));
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_busy", rx_busy, 1);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_valid", rx_valid, 0);
    chk("mr_data", rx_data_out, 8'h00);
    chk("mr_ovr", overrun_error, 0);
    chk("mr_busy", rx_busy, 0);
    chk("mr_perr", parity_bit_error, 0);
    chk("mr_serr", stop_bit_error, 0);
    rstn = 1'b1;
    vld_cnt = 0;
    repeat (200) @(negedge clk);
    chk("mr_idle_vcnt", vld_cnt, 0);
    chk("mr_idle_busy", rx_busy, 0);
    send_frame(8'h96, 1'b0, 1'b1);
    expect_frame("r96", 8'h96, 1'b0, 1'b0);
    chk("r96_ovr", overrun_error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27, meaning clk cycles per 16x-oversample tick (legal range 2..4095).
REQ-002 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port rx_ready, input, 1 bit: consumer accepts the held byte.
REQ-007 SHALL have port rx_data_out, output, 8 bits: received byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: rx_data_out and the error flags are valid.
REQ-009 SHALL have port parity_bit_error, output, 1 bit: parity mismatch on the held frame.
REQ-010 SHALL have port stop_bit_error, output, 1 bit: stop bit sampled low on the held frame.
REQ-011 SHALL have port overrun_error, output, 1 bit: sticky flag, set when a frame was dropped.
REQ-012 SHALL have port rx_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 Frame format SHALL be: 1 start (0), 8 data bits LSB first, 1 parity, 1 stop (1).
REQ-014 rx_in SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic uses the synchronized value rxs.
REQ-015 Tick divider: counter runs 0..CLK_DIV-1; one-cycle tick when it equals CLK_DIV-1; it is cleared on the IDLE->START transition so tick phase aligns to the start edge.
REQ-016 Sample counter: 4 bits, increments per tick, wraps 15->0; a wrap marks one bit period.
REQ-017 Each bit value SHALL be the majority vote of rxs sampled on the ticks where the sample counter equals 7, 8 and 9.
REQ-018 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE->START SHALL occur when rxs==0; the sample counter is cleared on this transition.
REQ-020 START: at the sample-counter wrap, vote==1 -> IDLE (false start, no output change); vote==0 -> DATA with bit index 0.
REQ-021 DATA: at each wrap, shift the vote into bit[index]; after index 7 -> PARITY.
REQ-022 PARITY: at wrap, store the vote -> STOP.
REQ-023 STOP: frame completes on the tick where the sample counter reaches 9, i.e. at mid-stop-bit rather than at the wrap; the next state is IDLE.
REQ-024 On completion with rx_valid==0 or (rx_valid && rx_ready) in the same cycle, the following cycle SHALL load:
- rx_data_out = data
- parity_bit_error = (XOR of data ^ parity bit) != PARITY_ODD
- stop_bit_error = ~stop vote
- rx_valid = 1
REQ-025 On completion with rx_valid==1 and rx_ready==0, the frame SHALL be dropped, the held outputs unchanged, and overrun_error set to 1.
REQ-026 rx_valid SHALL clear the cycle after rx_valid && rx_ready, unless a completion loads in that same cycle (REQ-024 takes priority).
REQ-027 Frames with parity or stop errors SHALL still be delivered with the data and error flags set.
REQ-028 overrun_error SHALL clear only on reset.
REQ-029 A low rxs during IDLE occurring in the same cycle as the STOP->IDLE transition SHALL be detected on the next cycle; no start edge is lost.
REQ-030 rx_busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-031 While rstn==0, all outputs and state SHALL take these values:
- state = IDLE
- rx_data_out = 8'h00
- rx_valid, parity_bit_error, stop_bit_error, overrun_error, rx_busy = 0
- counters = 0
- synchronizer flops = 1
REQ-032 Reset asserted mid-frame SHALL abort the frame with no output; after release the block waits in IDLE for the next rxs==0.

Verification (CLK_DIV=4, i.e. 64 clk per bit, rx_ready=1 unless stated)
REQ-033 Frame 0xA5, parity 0, stop 1 -> rx_valid=1 for 1 cycle, rx_data_out=8'hA5, both error flags 0.
REQ-034 Frame 0x01, parity 0 (wrong for even) -> rx_data_out=8'h01, parity_bit_error=1, stop_bit_error=0.
REQ-035 Frame 0x3C, stop 0, line high afterwards, then frame 0x5A -> first frame stop_bit_error=1; second frame 8'h5A with no errors.
REQ-036 rx_in low for 20 clk then high -> START returns to IDLE, rx_valid stays 0, rx_busy drops to 0 within 64 clk.
REQ-037 rx_ready=0, frames 0x11 then 0x22 -> rx_data_out stays 8'h11, overrun_error=1; raise rx_ready -> rx_valid clears.
REQ-038 rstn pulsed low during data bit 4 of 0x77, then full frame 0x96 -> all outputs at reset values; then 8'h96 with no errors.
